// File: rtl/wb_interconnect_rr_nxm.sv
// N-initiator x M-target Wishbone interconnect: registered per-target round-robin grants with
// cycle locking and an internal error responder. Optional per-target watchdog: WB_INTERCONNECT_TIMEOUT_EN.
module wb_interconnect_rr_nxm #(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int N_INITIATORS   = 2,
    parameter int N_TARGETS      = 4,
    parameter logic [N_TARGETS*WB_ADDR_WIDTH-1:0] I_ADR_MASK = {N_TARGETS{32'hF000_0000}},
    parameter logic [N_TARGETS*WB_ADDR_WIDTH-1:0] T_ADR =
        {32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000},
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [N_INITIATORS*WB_ADDR_WIDTH-1:0]     t_adr,
    input  logic [N_INITIATORS*WB_DATA_WIDTH-1:0]     t_dat_w,
    output logic [N_INITIATORS*WB_DATA_WIDTH-1:0]     t_dat_r,
    input  logic [N_INITIATORS-1:0]                   t_cyc,
    input  logic [N_INITIATORS-1:0]                   t_stb,
    input  logic [N_INITIATORS-1:0]                   t_we,
    input  logic [N_INITIATORS*WB_DATA_WIDTH/8-1:0]   t_sel,
    output logic [N_INITIATORS-1:0]                   t_ack,
    output logic [N_INITIATORS-1:0]                   t_err,
    output logic [N_TARGETS*WB_ADDR_WIDTH-1:0]        i_adr,
    output logic [N_TARGETS*WB_DATA_WIDTH-1:0]        i_dat_w,
    output logic [N_TARGETS*WB_DATA_WIDTH/8-1:0]      i_sel,
    output logic [N_TARGETS-1:0]                      i_cyc,
    output logic [N_TARGETS-1:0]                      i_stb,
    output logic [N_TARGETS-1:0]                      i_we,
    input  logic [N_TARGETS*WB_DATA_WIDTH-1:0]        i_dat_r,
    input  logic [N_TARGETS-1:0]                      i_ack,
    input  logic [N_TARGETS-1:0]                      i_err
);

    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = WB_DATA_WIDTH;
    localparam int SW = WB_DATA_WIDTH / 8;
    localparam int IW = (N_INITIATORS > 1) ? $clog2(N_INITIATORS) : 1;
    localparam int TW = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;

    logic [N_TARGETS-1:0]    busy_q, busy_d;
    logic [IW-1:0]           owner_q [N_TARGETS];
    logic [IW-1:0]           owner_d [N_TARGETS];
    logic [IW-1:0]           last_q  [N_TARGETS];
    logic [IW-1:0]           last_d  [N_TARGETS];
    logic [N_INITIATORS-1:0] err_q, err_d;

    logic [N_INITIATORS-1:0] hit_vld_s;
    logic [TW-1:0]           hit_idx_s [N_INITIATORS];
    logic [N_INITIATORS-1:0] own_vld_s;
    logic [TW-1:0]           own_tgt_s [N_INITIATORS];
    logic [N_INITIATORS-1:0] req_s     [N_TARGETS];
    logic [IW:0]             pick_s    [N_TARGETS];
    logic [N_TARGETS-1:0]    rel_s;
    logic [N_TARGETS-1:0]    stb_raw_s;
    logic [N_TARGETS-1:0]    tmo_s;

    function automatic logic tgt_hit(input logic [AW-1:0] adr, input int m);
        return (adr & I_ADR_MASK[(N_TARGETS-1-m)*AW +: AW]) == T_ADR[(N_TARGETS-1-m)*AW +: AW];
    endfunction

    // Returns {found, index} of the first requester after base, wrapping modulo N_INITIATORS.
    function automatic logic [IW:0] rr_pick(input logic [N_INITIATORS-1:0] req,
                                            input logic [IW-1:0] base);
        logic [IW:0] pick;
        int          c;
        pick = '0;
        for (int o = 1; o <= N_INITIATORS; o++) begin
            c    = (int'(base) + o) % N_INITIATORS;
            pick = (~pick[IW] & req[c]) ? {1'b1, IW'(c)} : pick;
        end
        return pick;
    endfunction

    // Address decode per initiator; iterating downward lets the lowest matching target win.
    always_comb begin
        for (int n = 0; n < N_INITIATORS; n++) begin
            hit_vld_s[n] = 1'b0;
            hit_idx_s[n] = '0;
            for (int m = N_TARGETS - 1; m >= 0; m--) begin
                hit_vld_s[n] = hit_vld_s[n] | tgt_hit(t_adr[n*AW +: AW], m);
                hit_idx_s[n] = tgt_hit(t_adr[n*AW +: AW], m) ? TW'(m) : hit_idx_s[n];
            end
        end
    end

    // Which target (if any) each initiator currently owns.
    always_comb begin
        for (int n = 0; n < N_INITIATORS; n++) begin
            own_vld_s[n] = 1'b0;
            own_tgt_s[n] = '0;
            for (int m = 0; m < N_TARGETS; m++) begin
                own_vld_s[n] = own_vld_s[n] | (busy_q[m] & (owner_q[m] == IW'(n)));
                own_tgt_s[n] = (busy_q[m] & (owner_q[m] == IW'(n))) ? TW'(m) : own_tgt_s[n];
            end
        end
    end

    // Grant next-state: a release hands straight to the next requester after the old owner.
    always_comb begin
        for (int m = 0; m < N_TARGETS; m++) begin
            for (int n = 0; n < N_INITIATORS; n++) begin
                req_s[m][n] = t_cyc[n] & t_stb[n] & hit_vld_s[n] &
                              (hit_idx_s[n] == TW'(m)) & ~own_vld_s[n];
            end
            rel_s[m]  = busy_q[m] & (~t_cyc[owner_q[m]] | tmo_s[m]);
            pick_s[m] = rr_pick(req_s[m], busy_q[m] ? owner_q[m] : last_q[m]);
            if (~busy_q[m] | rel_s[m]) begin
                busy_d[m]  = pick_s[m][IW];
                owner_d[m] = pick_s[m][IW] ? pick_s[m][IW-1:0] : owner_q[m];
                last_d[m]  = busy_q[m] ? owner_q[m] : last_q[m];
            end else begin
                busy_d[m]  = busy_q[m];
                owner_d[m] = owner_q[m];
                last_d[m]  = last_q[m];
            end
        end
    end

    // Error responder: unmapped address, or an owner strobing outside its granted target.
    always_comb begin
        for (int n = 0; n < N_INITIATORS; n++) begin
            err_d[n] = t_cyc[n] & t_stb[n] & ~err_q[n] &
                       (~hit_vld_s[n] | (own_vld_s[n] & (hit_idx_s[n] != own_tgt_s[n])));
        end
    end

    // Downstream mirror of each owner; the strobe only reaches the slave the owner decodes to.
    always_comb begin
        for (int m = 0; m < N_TARGETS; m++) begin
            stb_raw_s[m] = busy_q[m] & t_stb[owner_q[m]] & hit_vld_s[owner_q[m]] &
                           (hit_idx_s[owner_q[m]] == TW'(m));
            i_cyc[m] = busy_q[m] & t_cyc[owner_q[m]] & ~tmo_s[m];
            i_stb[m] = stb_raw_s[m] & ~tmo_s[m];
            i_we[m]  = busy_q[m] & t_we[owner_q[m]];
            i_adr[m*AW +: AW]   = busy_q[m] ? t_adr[int'(owner_q[m])*AW +: AW]   : '0;
            i_dat_w[m*DW +: DW] = busy_q[m] ? t_dat_w[int'(owner_q[m])*DW +: DW] : '0;
            i_sel[m*SW +: SW]   = busy_q[m] ? t_sel[int'(owner_q[m])*SW +: SW]   : '0;
        end
    end

    // Upstream responses go only to the owner; everyone else sees zeros.
    always_comb begin
        for (int n = 0; n < N_INITIATORS; n++) begin
            t_ack[n] = own_vld_s[n] & i_ack[own_tgt_s[n]];
            t_err[n] = err_q[n] | (own_vld_s[n] & (i_err[own_tgt_s[n]] | tmo_s[own_tgt_s[n]]));
            t_dat_r[n*DW +: DW] = own_vld_s[n] ? i_dat_r[int'(own_tgt_s[n])*DW +: DW] : '0;
        end
    end

    // Grant and error-responder state.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
            err_q  <= '0;
            for (int m = 0; m < N_TARGETS; m++) begin
                owner_q[m] <= '0;
                last_q[m]  <= IW'(N_INITIATORS - 1);
            end
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
            for (int m = 0; m < N_TARGETS; m++) begin
                owner_q[m] <= owner_d[m];
                last_q[m]  <= last_d[m];
            end
        end
    end

`ifdef WB_INTERCONNECT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0]        cnt_q [N_TARGETS];
    logic [CW-1:0]        cnt_d [N_TARGETS];
    logic [N_TARGETS-1:0] tmo_q, tmo_d;

    // Watchdog: counts strobed cycles without a slave response; fires a one-cycle abort.
    always_comb begin
        for (int m = 0; m < N_TARGETS; m++) begin
            if (~busy_q[m] | i_ack[m] | i_err[m] | tmo_q[m]) begin
                cnt_d[m] = '0;
                tmo_d[m] = 1'b0;
            end else if (stb_raw_s[m] && (cnt_q[m] == CW'(TIMEOUT_CYCLES - 1))) begin
                cnt_d[m] = '0;
                tmo_d[m] = 1'b1;
            end else if (stb_raw_s[m]) begin
                cnt_d[m] = cnt_q[m] + CW'(1);
                tmo_d[m] = 1'b0;
            end else begin
                cnt_d[m] = cnt_q[m];
                tmo_d[m] = 1'b0;
            end
        end
    end

    // Watchdog state.
    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_q <= '0;
            for (int m = 0; m < N_TARGETS; m++) cnt_q[m] <= '0;
        end else begin
            tmo_q <= tmo_d;
            for (int m = 0; m < N_TARGETS; m++) cnt_q[m] <= cnt_d[m];
        end
    end

    assign tmo_s = tmo_q;
`else
    assign tmo_s = '0;
`endif

endmodule

// File: tb/tb_wb_interconnect_rr_nxm.sv
// Directed self-checking bench for wb_interconnect_rr_nxm (2 initiators, 4 targets, simple slaves).
module tb_wb_interconnect_rr_nxm;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NI  = 2;
    localparam int NT  = 4;
    localparam int SW  = 4;
    localparam int TMO = 8;

    logic            clock = 1'b0;
    logic            reset;
    logic [NI*AW-1:0] t_adr;
    logic [NI*DW-1:0] t_dat_w, t_dat_r;
    logic [NI-1:0]    t_cyc, t_stb, t_we, t_ack, t_err;
    logic [NI*SW-1:0] t_sel;
    logic [NT*AW-1:0] i_adr;
    logic [NT*DW-1:0] i_dat_w, i_dat_r;
    logic [NT*SW-1:0] i_sel;
    logic [NT-1:0]    i_cyc, i_stb, i_we, i_ack, i_err;
    logic [NT-1:0]    ack_q, slave_en;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    wb_interconnect_rr_nxm #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset),
        .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(t_dat_r),
        .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_sel(t_sel),
        .t_ack(t_ack), .t_err(t_err),
        .i_adr(i_adr), .i_dat_w(i_dat_w), .i_sel(i_sel),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we),
        .i_dat_r(i_dat_r), .i_ack(i_ack), .i_err(i_err)
    );

    // Slaves: ack the cycle after a strobe is seen, one ack per strobe; fixed read data per target.
    always @(posedge clock) begin
        if (reset) ack_q <= '0;
        else       ack_q <= i_stb & ~ack_q & slave_en;
    end
    assign i_ack   = ack_q;
    assign i_err   = '0;
    assign i_dat_r = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};

    task automatic set_m(input int n, input logic cyc, input logic stb, input logic [31:0] adr);
        t_cyc[n] = cyc;
        t_stb[n] = stb;
        t_adr[n*AW +: AW] = adr;
    endtask

    task automatic idle_all();
        t_cyc = '0; t_stb = '0; t_we = '0; t_adr = '0;
        t_sel = '1; t_dat_w = 64'h1111_2222_3333_4444;
    endtask

    task automatic do_reset();
        @(negedge clock);
        idle_all();
        slave_en = '1;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        slave_en = '1;
        idle_all();
        set_m(0, 1'b1, 1'b1, 32'h1000_0000);
        @(negedge clock);
        @(negedge clock);
        #1;
        n_tests++; if (i_cyc !== 4'b0000) begin n_fail++; $display("FAIL reset_i_cyc: got %b want 0000", i_cyc); end
        n_tests++; if (i_stb !== 4'b0000) begin n_fail++; $display("FAIL reset_i_stb: got %b want 0000", i_stb); end
        n_tests++; if (t_ack !== 2'b00) begin n_fail++; $display("FAIL reset_t_ack: got %b want 00", t_ack); end
        n_tests++; if (t_err !== 2'b00) begin n_fail++; $display("FAIL reset_t_err: got %b want 00", t_err); end
        n_tests++; if (t_dat_r !== 64'h0) begin n_fail++; $display("FAIL reset_t_dat_r: got %h want 0", t_dat_r); end
        idle_all();
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        @(negedge clock);
        set_m(0, 1'b1, 1'b1, 32'h2000_0010);
        #1;
        n_tests++; if (i_stb !== 4'b0000) begin n_fail++; $display("FAIL single_arb_latency: i_stb=%b want 0000", i_stb); end
        @(negedge clock); #1;
        n_tests++; if (i_stb !== 4'b0010) begin n_fail++; $display("FAIL single_i_stb: got %b want 0010", i_stb); end
        n_tests++; if (i_adr[1*AW +: AW] !== 32'h2000_0010) begin n_fail++; $display("FAIL single_i_adr: got %h want 20000010", i_adr[1*AW +: AW]); end
        n_tests++; if (t_ack !== 2'b00) begin n_fail++; $display("FAIL single_early_ack: got %b want 00", t_ack); end
        @(negedge clock); #1;
        n_tests++; if (t_ack !== 2'b01) begin n_fail++; $display("FAIL single_ack: got %b want 01", t_ack); end
        n_tests++; if (t_dat_r[31:0] !== 32'hD000_0001) begin n_fail++; $display("FAIL single_dat_r: got %h want d0000001", t_dat_r[31:0]); end
        n_tests++; if (t_dat_r[63:32] !== 32'h0) begin n_fail++; $display("FAIL single_unowned_dat_r: got %h want 0", t_dat_r[63:32]); end
        @(negedge clock);
        set_m(0, 1'b0, 1'b0, 32'h0);
        #1;
        n_tests++; if (i_cyc !== 4'b0000) begin n_fail++; $display("FAIL single_cyc_drop: got %b want 0000", i_cyc); end
    endtask

    task automatic test_round_robin();
        int order[$];
        int cnt[2];
        bit drop[2];
        cnt = '{0, 0};
        drop = '{1'b0, 1'b0};
        do_reset();
        for (int c = 0; c < 100 && (cnt[0] < 4 || cnt[1] < 4); c++) begin
            @(negedge clock);
            for (int n = 0; n < NI; n++) begin
                if (drop[n]) begin
                    set_m(n, 1'b0, 1'b0, 32'h1000_0000);
                    drop[n] = 1'b0;
                end else if (cnt[n] < 4) begin
                    set_m(n, 1'b1, 1'b1, 32'h1000_0000);
                end else begin
                    set_m(n, 1'b0, 1'b0, 32'h1000_0000);
                end
            end
            #1;
            for (int n = 0; n < NI; n++) begin
                if (t_ack[n]) begin
                    order.push_back(n);
                    cnt[n]++;
                    drop[n] = 1'b1;
                end
            end
        end
        n_tests++; if (order.size() != 8) begin n_fail++; $display("FAIL rr_count: got %0d acks want 8", order.size()); end
        for (int i = 0; i < order.size(); i++) begin
            n_tests++;
            if (order[i] != i % 2) begin n_fail++; $display("FAIL rr_order[%0d]: got master %0d want %0d", i, order[i], i % 2); end
        end
        idle_all();
    endtask

    task automatic test_lock();
        int m1cnt = 0;
        int drop_cyc = -1;
        int first_m0 = -1;
        int early = 0;
        bit m0_done = 1'b0;
        do_reset();
        for (int c = 0; c < 60 && !m0_done; c++) begin
            @(negedge clock);
            if (m1cnt == 3 && drop_cyc < 0) begin
                set_m(1, 1'b0, 1'b0, 32'h3000_0000);
                drop_cyc = c;
            end else if (m1cnt < 3) begin
                set_m(1, 1'b1, 1'b1, 32'h3000_0000);
            end else begin
                set_m(1, 1'b0, 1'b0, 32'h3000_0000);
            end
            set_m(0, (c >= 1), (c >= 1), 32'h3000_0004);
            #1;
            if (t_ack[1]) m1cnt++;
            if (first_m0 < 0 && i_stb[2] && i_adr[2*AW +: AW] == 32'h3000_0004) first_m0 = c;
            if (t_ack[0]) begin
                if (drop_cyc < 0) early++;
                m0_done = 1'b1;
                n_tests++; if (t_dat_r[31:0] !== 32'hD000_0002) begin n_fail++; $display("FAIL lock_m0_dat_r: got %h want d0000002", t_dat_r[31:0]); end
            end
        end
        n_tests++; if (m1cnt != 3) begin n_fail++; $display("FAIL lock_m1_acks: got %0d want 3", m1cnt); end
        n_tests++; if (early != 0) begin n_fail++; $display("FAIL lock_m0_early: got %0d acks want 0", early); end
        n_tests++; if (drop_cyc != 7) begin n_fail++; $display("FAIL lock_drop_cycle: got %0d want 7", drop_cyc); end
        n_tests++; if (first_m0 != 8) begin n_fail++; $display("FAIL lock_m0_grant: got cycle %0d want 8", first_m0); end
        n_tests++; if (!m0_done) begin n_fail++; $display("FAIL lock_m0_done: got 0 want 1"); end
        idle_all();
    endtask

    task automatic test_unmapped();
        do_reset();
        @(negedge clock);
        set_m(0, 1'b1, 1'b1, 32'h9000_0000);
        #1;
        n_tests++; if (t_err !== 2'b00) begin n_fail++; $display("FAIL unmapped_err_early: got %b want 00", t_err); end
        @(negedge clock); #1;
        n_tests++; if (t_err !== 2'b01) begin n_fail++; $display("FAIL unmapped_err: got %b want 01", t_err); end
        n_tests++; if (i_cyc !== 4'b0000) begin n_fail++; $display("FAIL unmapped_i_cyc: got %b want 0000", i_cyc); end
        @(negedge clock); #1;
        n_tests++; if (t_err !== 2'b00) begin n_fail++; $display("FAIL unmapped_err_gap: got %b want 00", t_err); end
        idle_all();
    endtask

    task automatic test_wrong_target();
        do_reset();
        @(negedge clock);
        set_m(0, 1'b1, 1'b1, 32'h1000_0000);
        @(negedge clock);
        set_m(0, 1'b1, 1'b1, 32'h2000_0000);
        #1;
        n_tests++; if (i_cyc !== 4'b0001) begin n_fail++; $display("FAIL wrong_tgt_cyc: got %b want 0001", i_cyc); end
        n_tests++; if (i_stb !== 4'b0000) begin n_fail++; $display("FAIL wrong_tgt_stb: got %b want 0000", i_stb); end
        @(negedge clock); #1;
        n_tests++; if (t_err !== 2'b01) begin n_fail++; $display("FAIL wrong_tgt_err: got %b want 01", t_err); end
        n_tests++; if (i_cyc !== 4'b0001) begin n_fail++; $display("FAIL wrong_tgt_no_second: got %b want 0001", i_cyc); end
        @(negedge clock);
        idle_all();
        @(negedge clock); #1;
        n_tests++; if (i_cyc !== 4'b0000) begin n_fail++; $display("FAIL wrong_tgt_release: got %b want 0000", i_cyc); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        slave_en[2] = 1'b0;
        @(negedge clock);
        set_m(0, 1'b1, 1'b1, 32'h3000_0000);
        @(negedge clock); #1;
        n_tests++; if (i_cyc !== 4'b0100) begin n_fail++; $display("FAIL rmid_busy: got %b want 0100", i_cyc); end
        reset = 1'b1;
        @(negedge clock); #1;
        n_tests++; if (i_cyc !== 4'b0000) begin n_fail++; $display("FAIL rmid_cyc: got %b want 0000", i_cyc); end
        n_tests++; if (t_ack !== 2'b00) begin n_fail++; $display("FAIL rmid_ack: got %b want 00", t_ack); end
        n_tests++; if (t_err !== 2'b00) begin n_fail++; $display("FAIL rmid_err: got %b want 00", t_err); end
        reset = 1'b0;
        @(negedge clock);
        slave_en[2] = 1'b1;
        #1;
        n_tests++; if (i_stb !== 4'b0100) begin n_fail++; $display("FAIL rmid_regrant: got %b want 0100", i_stb); end
        @(negedge clock); #1;
        n_tests++; if (t_ack !== 2'b01) begin n_fail++; $display("FAIL rmid_ack_after: got %b want 01", t_ack); end
        idle_all();
    endtask

`ifdef WB_INTERCONNECT_TIMEOUT_EN
    task automatic test_timeout();
        int stb_rise = -1;
        int err_at = -1;
        do_reset();
        slave_en[3] = 1'b0;
        @(negedge clock);
        set_m(0, 1'b1, 1'b1, 32'h4000_0000);
        for (int c = 1; c < 30 && err_at < 0; c++) begin
            @(negedge clock); #1;
            if (stb_rise < 0 && i_stb[3]) stb_rise = c;
            if (t_err[0]) begin
                err_at = c;
                n_tests++; if (i_cyc[3] !== 1'b0 || i_stb[3] !== 1'b0) begin n_fail++; $display("FAIL tmo_forced_low: cyc=%b stb=%b want 0 0", i_cyc[3], i_stb[3]); end
            end
        end
        n_tests++; if (err_at - stb_rise != TMO || stb_rise < 0) begin n_fail++; $display("FAIL tmo_delay: got %0d want %0d", err_at - stb_rise, TMO); end
        @(negedge clock); #1;
        n_tests++; if (i_cyc[3] !== 1'b0) begin n_fail++; $display("FAIL tmo_idle: got %b want 0", i_cyc[3]); end
        idle_all();
        slave_en = '1;
    endtask
`else
    task automatic test_hung_slave();
        int errs = 0;
        do_reset();
        slave_en[3] = 1'b0;
        @(negedge clock);
        set_m(0, 1'b1, 1'b1, 32'h4000_0000);
        for (int c = 0; c < 20; c++) begin
            @(negedge clock); #1;
            if (t_err[0]) errs++;
        end
        n_tests++; if (errs != 0) begin n_fail++; $display("FAIL hung_no_err: got %0d errors want 0", errs); end
        n_tests++; if (i_stb !== 4'b1000) begin n_fail++; $display("FAIL hung_stalled: got %b want 1000", i_stb); end
        idle_all();
        slave_en = '1;
    endtask
`endif

    initial begin
        reset = 1'b1;
        slave_en = '1;
        idle_all();
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_unmapped();
        test_wrong_target();
        test_reset_mid();
`ifdef WB_INTERCONNECT_TIMEOUT_EN
        test_timeout();
`else
        test_hung_slave();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
